// File: rtl/scalar_pkg.sv
// Shared sizing for the 2:1 grayscale downscaler and the rounding 2x2 box-average helper.
// Latency: none (pure definitions); no flow control.
package scalar_pkg;

  localparam int H_PIXELS = 1920;
  localparam int V_PIXELS = 1080;
  localparam int OUT_W    = H_PIXELS / 2;
  localparam int SIZE     = OUT_W * (V_PIXELS / 2);
  localparam int AW       = $clog2(SIZE);

  // top holds the even-row pair sum; the two odd-row pixels complete the block.
  function automatic logic [7:0] box_avg(input logic [8:0] top,
                                         input logic [7:0] p,
                                         input logic [7:0] d);
    logic [9:0] s;
    s = 10'(top) + 10'(p) + 10'(d) + 10'd2;
    return s[9:2];
  endfunction

endpackage

// File: rtl/scalar_ram.sv
// Single-port scaled-frame store, write-first, registered read.
// Latency: 1 cycle write-to-readback; no backpressure, one access per cycle.
module scalar_ram
  import scalar_pkg::*;
#(
  parameter int DEPTH  = SIZE,
  parameter int ADDR_W = AW
) (
  input  logic              clk,
  input  logic              HRESETn,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        wdat,
  output logic [7:0]        rdat
);

  logic [7:0] mem [DEPTH];
  logic [7:0] rd_q, rd_d;

  always_comb begin
    rd_d = we ? wdat : mem[addr];
  end

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdat;
    if (!HRESETn) rd_q <= 8'd0;
    else          rd_q <= rd_d;
  end

  assign rdat = rd_q;

endmodule

// File: rtl/scalar.sv
// 2:1 grayscale downscaler: rounded 2x2 box average written into an internal frame RAM.
// Latency: result strobed on the edge consuming a block's 4th pixel; enable=0 stalls, no backpressure.
module scalar #(
  parameter int H_PIXELS = scalar_pkg::H_PIXELS,
  parameter int V_PIXELS = scalar_pkg::V_PIXELS,
  parameter int AW       = $clog2((H_PIXELS / 2) * (V_PIXELS / 2))
) (
  input  logic          clk,
  input  logic          HRESETn,
  input  logic [7:0]    din,
  input  logic          enable,
  input  logic          H_sig,
  input  logic          V_sig,
  output logic [7:0]    dout,
  output logic          write_signal,
  output logic [AW-1:0] wa,
  output logic [7:0]    ram_out
);
  import scalar_pkg::*;

  localparam int OUT_PIX  = H_PIXELS / 2;
  localparam int RAM_SIZE = OUT_PIX * (V_PIXELS / 2);
  localparam int CW       = $clog2(H_PIXELS);
  localparam int RW       = $clog2(V_PIXELS + 1);

  logic [CW-1:0]      col_q, col_d;
  logic [RW-1:0]      row_q, row_d;
  logic [7:0]         p_q, p_d;
  logic               hsig_q, hsig_d;
  logic [7:0]         dout_q, dout_d;
  logic               wr_q, wr_d;
  logic [AW-1:0]      wa_q, wa_d;
  logic [OUT_PIX-1:0] lb_vld_q, lb_vld_d;

  logic [8:0]         lb_mem [OUT_PIX];
  logic               lb_we;
  logic [CW-2:0]      lb_idx;
  logic [8:0]         lb_wdat;

  logic               resync;
  logic [CW-1:0]      cur_col;
  logic [RW-1:0]      cur_row;

  always_comb begin
    col_d    = col_q;
    row_d    = row_q;
    p_d      = p_q;
    hsig_d   = H_sig;
    dout_d   = dout_q;
    wr_d     = 1'b0;
    wa_d     = wa_q;
    lb_vld_d = lb_vld_q;
    lb_we    = 1'b0;
    lb_wdat  = 9'(p_q) + 9'(din);

    // A line sync arriving mid-line means pixels were lost: jump to the next row.
    resync  = H_sig && !hsig_q && (col_q != '0);
    cur_col = resync ? '0 : col_q;
    cur_row = resync ? row_q + RW'(1) : row_q;
    lb_idx  = cur_col[CW-1:1];

    if (V_sig) begin
      col_d    = '0;
      row_d    = '0;
      p_d      = 8'd0;
      lb_vld_d = '0;
    end else begin
      col_d = cur_col;
      row_d = cur_row;
      if (enable && (cur_row < RW'(V_PIXELS))) begin
        if (cur_col == CW'(H_PIXELS - 1)) begin
          col_d = '0;
          row_d = cur_row + RW'(1);
        end else begin
          col_d = cur_col + CW'(1);
        end

        if (!cur_col[0]) begin
          p_d = din;
        end else if (!cur_row[0]) begin
          lb_we            = 1'b1;
          lb_vld_d[lb_idx] = 1'b1;
        end else if (lb_vld_q[lb_idx]) begin
          // Valid flag guards against a line truncated by resync leaving no partner sum.
          lb_vld_d[lb_idx] = 1'b0;
          wr_d             = 1'b1;
          dout_d           = box_avg(lb_mem[lb_idx], p_q, din);
          wa_d             = AW'(int'(cur_row[RW-1:1]) * OUT_PIX + int'(lb_idx));
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!HRESETn) begin
      col_q    <= '0;
      row_q    <= '0;
      p_q      <= 8'd0;
      hsig_q   <= 1'b0;
      dout_q   <= 8'd0;
      wr_q     <= 1'b0;
      wa_q     <= '0;
      lb_vld_q <= '0;
    end else begin
      col_q    <= col_d;
      row_q    <= row_d;
      p_q      <= p_d;
      hsig_q   <= hsig_d;
      dout_q   <= dout_d;
      wr_q     <= wr_d;
      wa_q     <= wa_d;
      lb_vld_q <= lb_vld_d;
    end
  end

  always_ff @(posedge clk) begin
    if (lb_we) lb_mem[lb_idx] <= lb_wdat;
  end

  assign dout         = dout_q;
  assign write_signal = wr_q;
  assign wa           = wa_q;

  scalar_ram #(
    .DEPTH  (RAM_SIZE),
    .ADDR_W (AW)
  ) u_ram (
    .clk     (clk),
    .HRESETn (HRESETn),
    .we      (wr_q),
    .addr    (wa_q),
    .wdat    (dout_q),
    .rdat    (ram_out)
  );

endmodule

// File: tb/tb_scalar.sv
// Scoreboarded bench for scalar on a reduced 16x8 frame; expected blocks come from the source image.
module tb_scalar;

  localparam int H  = 16;
  localparam int V  = 8;
  localparam int OW = H / 2;
  localparam int SZ = OW * (V / 2);
  localparam int AW = $clog2(SZ);

  logic          clk = 1'b0;
  logic          HRESETn = 1'b0;
  logic [7:0]    din = 8'd0;
  logic          enable = 1'b0;
  logic          H_sig = 1'b0;
  logic          V_sig = 1'b0;
  logic [7:0]    dout;
  logic          write_signal;
  logic [AW-1:0] wa;
  logic [7:0]    ram_out;

  scalar #(.H_PIXELS(H), .V_PIXELS(V), .AW(AW)) dut (
    .clk          (clk),
    .HRESETn      (HRESETn),
    .din          (din),
    .enable       (enable),
    .H_sig        (H_sig),
    .V_sig        (V_sig),
    .dout         (dout),
    .write_signal (write_signal),
    .wa           (wa),
    .ram_out      (ram_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    int addr;
    int dat;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_chk = 0;
  int   n_fail = 0;
  int   img[V][H];
  bit   gaps = 1'b0;
  int   wr_cnt = 0;
  int   last_wa = -1;
  int   rec[SZ];
  int   ref_rec[SZ];
  bit   ram_pend = 1'b0;
  int   ram_exp = 0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every strobe must match the oldest expected block; readback follows one cycle later.
  always @(negedge clk) begin
    if (!HRESETn) begin
      ram_pend = 1'b0;
    end else begin
      if (ram_pend) check("ram_readback", int'(ram_out), ram_exp);
      ram_pend = 1'b0;
      if (write_signal) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write_wa", int'(wa), -1);
        end else begin
          mon_e = exp_q.pop_front();
          check("dout", int'(dout), mon_e.dat);
          check("wa", int'(wa), mon_e.addr);
        end
        wr_cnt++;
        last_wa  = int'(wa);
        rec[wa]  = int'(dout);
        ram_pend = 1'b1;
        ram_exp  = int'(dout);
      end
    end
  end

  task automatic fill(input int mode);
    for (int r = 0; r < V; r++)
      for (int c = 0; c < H; c++)
        case (mode)
          0:       img[r][c] = 100;
          1:       img[r][c] = int'($urandom_range(0, 255));
          2:       img[r][c] = c & 255;
          default: img[r][c] = 255;
        endcase
  endtask

  task automatic pix(input int r, input int c);
    int n;
    int s;
    exp_t e;
    if (gaps) begin
      n = int'($urandom_range(0, 2));
      repeat (n) begin @(posedge clk); #1; end
    end
    if ((r % 2 == 1) && (c % 2 == 1)) begin
      s = img[r-1][c-1] + img[r-1][c] + img[r][c-1] + img[r][c];
      e.addr = (r / 2) * OW + c / 2;
      e.dat  = (s + 2) / 4;
      exp_q.push_back(e);
    end
    din    = 8'(img[r][c]);
    enable = 1'b1;
    @(posedge clk); #1;
    enable = 1'b0;
  endtask

  task automatic send_rows(input int r0, input int r1);
    for (int r = r0; r < r1; r++)
      for (int c = 0; c < H; c++) pix(r, c);
  endtask

  task automatic stray_pix();
    din    = 8'($urandom_range(0, 255));
    enable = 1'b1;
    @(posedge clk); #1;
    enable = 1'b0;
  endtask

  task automatic vsync();
    V_sig = 1'b1;
    @(posedge clk); #1;
    V_sig = 1'b0;
  endtask

  task automatic hsync();
    H_sig = 1'b1;
    @(posedge clk); #1;
    H_sig = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic drain();
    repeat (3) begin @(posedge clk); #1; end
    check("queue_empty", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, n_fail=%0d", n_fail);
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) begin @(posedge clk); #1; end
    check("rst_dout", int'(dout), 0);
    check("rst_write_signal", int'(write_signal), 0);
    check("rst_wa", int'(wa), 0);
    check("rst_ram_out", int'(ram_out), 0);
    HRESETn = 1'b1;
    @(posedge clk); #1;

    // Constant frame, continuous enable.
    fill(0);
    wr_cnt = 0;
    send_rows(0, V);
    drain();
    check("const_strobes", wr_cnt, SZ);
    check("const_last_wa", last_wa, SZ - 1);

    // Pixels beyond the last row are ignored until V_sig.
    wr_cnt = 0;
    repeat (6) stray_pix();
    drain();
    check("past_end_writes", wr_cnt, 0);
    vsync();

    // Directed first blocks: 10/20/30/41, then 1/1/1/2, then all-255.
    fill(3);
    img[0][0] = 10; img[0][1] = 20; img[1][0] = 30; img[1][1] = 41;
    img[0][2] = 1;  img[0][3] = 1;  img[1][2] = 1;  img[1][3] = 2;
    send_rows(0, 1);
    pix(1, 0);
    pix(1, 1);
    check("first_blk_strobe", int'(write_signal), 1);
    check("first_blk_dout", int'(dout), 25);
    check("first_blk_wa", int'(wa), 0);
    @(posedge clk); #1;
    check("first_blk_ram_out", int'(ram_out), 25);
    check("strobe_one_cycle", int'(write_signal), 0);
    check("dout_holds", int'(dout), 25);
    pix(1, 2);
    pix(1, 3);
    check("pattern_1112_dout", int'(dout), 1);
    check("pattern_1112_wa", int'(wa), 1);
    pix(1, 4);
    pix(1, 5);
    check("all_255_dout", int'(dout), 255);
    for (int c = 6; c < H; c++) pix(1, c);
    send_rows(2, V);
    drain();
    vsync();

    // Ramp: gapless reference run, then the same frame with random enable gaps.
    fill(2);
    for (int i = 0; i < SZ; i++) rec[i] = -1;
    gaps = 1'b0;
    send_rows(0, V);
    drain();
    for (int i = 0; i < SZ; i++) ref_rec[i] = rec[i];
    vsync();
    for (int i = 0; i < SZ; i++) rec[i] = -1;
    gaps = 1'b1;
    send_rows(0, V);
    drain();
    gaps = 1'b0;
    for (int i = 0; i < SZ; i++) check("gapped_vs_gapless", rec[i], ref_rec[i]);
    vsync();

    // V_sig mid-frame restarts addressing at 0 and drops the pending pair.
    fill(1);
    send_rows(0, 5);
    pix(5, 0);
    pix(5, 1);
    pix(5, 2);
    drain();
    vsync();
    fill(1);
    send_rows(0, 1);
    pix(1, 0);
    pix(1, 1);
    check("vsig_restart_strobe", int'(write_signal), 1);
    check("vsig_restart_wa", int'(wa), 0);
    for (int c = 2; c < H; c++) pix(1, c);
    send_rows(2, V);
    drain();
    vsync();

    // H_sig at col 0 is ignored; mid-line H_sig truncates the line and advances the row.
    fill(1);
    wr_cnt = 0;
    hsync();
    send_rows(0, 3);
    for (int c = 0; c < 10; c++) pix(3, c);
    hsync();
    send_rows(4, V);
    drain();
    check("hsync_frame_writes", wr_cnt, SZ - (OW - 5));
    vsync();

    // Reset mid-frame clears outputs; the next frame starts from row 0.
    fill(1);
    for (int c = 0; c < H; c++) img[1][c] = 200;
    send_rows(0, 3);
    drain();
    HRESETn = 1'b0;
    @(posedge clk); #1;
    check("midrst_dout", int'(dout), 0);
    check("midrst_write_signal", int'(write_signal), 0);
    check("midrst_wa", int'(wa), 0);
    check("midrst_ram_out", int'(ram_out), 0);
    HRESETn = 1'b1;
    @(posedge clk); #1;
    fill(1);
    wr_cnt = 0;
    send_rows(0, V);
    drain();
    check("post_rst_strobes", wr_cnt, SZ);
    check("post_rst_last_wa", last_wa, SZ - 1);
    vsync();

    // Random frames, alternating gapped/gapless.
    for (int k = 0; k < 6; k++) begin
      fill(1);
      gaps = k[0];
      wr_cnt = 0;
      send_rows(0, V);
      drain();
      check("rand_frame_strobes", wr_cnt, SZ);
      vsync();
    end
    gaps = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
